// File: rtl/seq_pattern_det_pkg.sv
// Shared types and default sizing for the serial pattern detector.
package seq_pattern_det_pkg;

  typedef enum logic {
    UNCFG = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/seq_pattern_hist.sv
// History shift register plus fill counter saturating at MAX_LEN.
module seq_pattern_hist
  import seq_pattern_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int FILL_W  = $clog2(DEF_MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               shift,
  input  logic               shift_bit,
  input  logic               fill_clr,
  output logic [MAX_LEN-2:0] hist,
  output logic [FILL_W-1:0]  fill
);

  localparam int HIST_W = MAX_LEN - 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= HIST_W'({hist, shift_bit});
      // a non-overlapping match restarts the count of fresh samples
      if (fill_clr)
        fill <= '0;
      else if (fill != FILL_MAX)
        fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/seq_pattern_det.sv
// Configurable serial pattern detector with Mealy/Moore match flags.
// Define SEQ_PATTERN_DET_CNT_EN to build the saturating match counter.
module seq_pattern_det
  import seq_pattern_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  input  logic                           in_valid,
  input  logic                           in_bit,
  output logic                           mealy_y,
  output logic                           moore_y,
  output logic [CNT_W-1:0]               match_cnt
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  state_t             state;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill;
  logic               accept;
  logic               shift;
  logic               fill_ok;
  logic               match_p0;
  logic               match_p1;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;

  assign cfg_ready = 1'b1;
  assign accept    = cfg_valid & cfg_ready;
  assign shift     = (state == RUN) && in_valid && !accept;
  assign window    = {hist, in_bit};
  assign fill_ok   = ({1'b0, fill} + 1'b1) >= {1'b0, len_q};

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      mask[i] = (i < int'(len_q));
  end

  assign match_p0 = shift && !reset && fill_ok && (((window ^ pat_q) & mask) == '0);
  assign mealy_y  = match_p0;
  assign moore_y  = match_p1;

  seq_pattern_hist #(
    .MAX_LEN (MAX_LEN),
    .FILL_W  (LEN_W)
  ) u_hist (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .shift     (shift),
    .shift_bit (in_bit),
    .fill_clr  (match_p0 && !ovl_q),
    .hist      (hist),
    .fill      (fill)
  );

  // control FSM and registered match flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= UNCFG;
      pat_q    <= '0;
      len_q    <= '0;
      ovl_q    <= 1'b0;
      match_p1 <= 1'b0;
    end else begin
      match_p1 <= match_p0;
      if (accept) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len;
        ovl_q <= cfg_overlap;
        state <= (cfg_len >= LEN_MIN && cfg_len <= LEN_MAX) ? RUN : UNCFG;
      end
    end
  end

`ifdef SEQ_PATTERN_DET_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] cnt_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_p1 <= '0;
    else if (accept)
      cnt_p1 <= '0;
    else if (match_p0)
      cnt_p1 <= sat_inc(cnt_p1);
  end

  assign match_cnt = cnt_p1;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_det.sv
// Randomized + directed scoreboard bench for seq_pattern_det against a sample-list model.
module tb_seq_pattern_det;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int CMAX    = (1 << CNT_W) - 1;
`ifdef SEQ_PATTERN_DET_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [7:0]       cfg_pattern = '0;
  logic [3:0]       cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             mealy_y;
  logic             moore_y;
  logic [CNT_W-1:0] match_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic mealy;
    logic moore;
    int   cnt;
  } exp_t;
  exp_t sbq[$];

  // reference model state: samples received since the last restart
  bit         m_run;
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         seen[$];
  int         m_cnt;
  bit         m_prev;

  seq_pattern_det #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .mealy_y     (mealy_y),
    .moore_y     (moore_y),
    .match_cnt   (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit model_match();
    int n;
    n = seen.size();
    if (n < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (seen[n - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step(input bit rst, input bit cv, input logic [7:0] cpat,
                      input int clen, input bit covl, input bit iv, input bit ib);
    exp_t e;
    bit   mm;
    @(posedge clk);
    #1;
    reset       = rst;
    cfg_valid   = cv;
    cfg_pattern = cpat;
    cfg_len     = 4'(clen);
    cfg_overlap = covl;
    in_valid    = iv;
    in_bit      = ib;
    mm = 1'b0;
    if (rst) begin
      m_run = 1'b0; m_pat = '0; m_len = 0; m_ovl = 1'b0;
      seen.delete(); m_cnt = 0; m_prev = 1'b0;
      e.moore = 1'b0;
      e.cnt   = 0;
    end else begin
      e.moore = m_prev;
      e.cnt   = CNT_EN ? m_cnt : 0;
      if (cv) begin
        m_pat = cpat; m_len = clen; m_ovl = covl;
        m_run = (clen >= 2 && clen <= MAX_LEN);
        seen.delete();
        m_cnt = 0;
      end else if (m_run && iv) begin
        seen.push_back(ib);
        mm = model_match();
        if (mm) begin
          if (m_cnt < CMAX) m_cnt++;
          if (!m_ovl) seen.delete();
        end
      end
      m_prev = mm;
    end
    e.mealy = mm;
    sbq.push_back(e);
  endtask

  task automatic feed(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--)
      step(0, 0, 8'h00, 0, 0, 1, bits[i]);
  endtask

  task automatic cfg(input logic [7:0] pat, input int len, input bit ovl);
    step(0, 1, pat, len, ovl, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  // monitor: every cycle the DUT presents its flags, compare against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("cfg_ready", int'(cfg_ready), 1);
        check("mealy_y", int'(mealy_y), int'(e.mealy));
        check("moore_y", int'(moore_y), int'(e.moore));
        check("match_cnt", int'(match_cnt), e.cnt);
      end
    end
  end

  initial begin
    int r;
    step(1, 0, 8'h00, 0, 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 1, 1);
    check("reset_cnt", int'(match_cnt), 0);

    // overlapping 1101
    cfg(8'b1101, 4, 1);
    feed(8'b1101101, 7);
    idle(2);
    check("cnt_overlap", int'(match_cnt), CNT_EN ? 2 : 0);

    // non-overlapping 1101
    cfg(8'b1101, 4, 0);
    feed(8'b1101101, 7);
    idle(2);
    check("cnt_no_overlap", int'(match_cnt), CNT_EN ? 1 : 0);

    // 1110 with an input gap
    cfg(8'b1110, 4, 1);
    feed(8'b11, 2);
    idle(2);
    feed(8'b110, 3);
    idle(2);

    // reset mid-pattern discards progress
    cfg(8'b1101, 4, 1);
    feed(8'b110, 3);
    step(1, 0, 8'h00, 0, 0, 1, 1);
    cfg(8'b1101, 4, 1);
    feed(8'b1, 1);
    idle(1);
    check("cnt_after_reset", int'(match_cnt), 0);

    // illegal lengths stay unconfigured
    cfg(8'b11, 0, 1);
    feed(8'b111111, 6);
    cfg(8'b11, 9, 1);
    feed(8'b111111, 6);

    // counter saturation
    cfg(8'b11, 2, 1);
    feed(8'b111111, 6);
    idle(2);
    check("cnt_saturate", int'(match_cnt), CNT_EN ? 3 : 0);

    // configuration wins over a matching sample
    cfg(8'b1101, 4, 1);
    feed(8'b110, 3);
    step(0, 1, 8'b1101, 4, 1, 1, 1);
    feed(8'b1, 1);
    idle(1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2)
        step(1, 0, 8'h00, 0, 0, 1, 1'($urandom));
      else if (r < 7)
        step(0, 1, 8'($urandom), (r < 6) ? $urandom_range(2, 4) : $urandom_range(0, 9),
             1'($urandom), 1'($urandom), 1'($urandom));
      else
        step(0, 0, 8'h00, 0, 0, ($urandom_range(0, 3) != 0), 1'($urandom));
    end
    idle(2);

    @(negedge clk);
    #1;
    check("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_pattern_det.md
SEQ_PATTERN_DET -- requirements
Module: seq_pattern_det

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits, legal range 2..32.
REQ-002 Parameter CNT_W, default 16: width of the match counter.
REQ-003 Port clk, input, 1 bit: clock; every register updates on its rising edge.
REQ-004 Port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port cfg_valid, input, 1 bit: a configuration word is offered.
REQ-006 Port cfg_ready, output, 1 bit: the block can accept configuration.
REQ-007 Port cfg_pattern, input, MAX_LEN bits: target pattern; bit [cfg_len-1] is the first bit received and bit [0] the last.
REQ-008 Port cfg_len, input, $clog2(MAX_LEN+1) bits: active pattern length.
REQ-009 Port cfg_overlap, input, 1 bit: 1 allows overlapping matches, 0 does not.
REQ-010 Port in_valid, input, 1 bit: in_bit is a valid sample this cycle.
REQ-011 Port in_bit, input, 1 bit: serial data bit.
REQ-012 Port mealy_y, output, 1 bit: combinational match flag for the current sample.
REQ-013 Port moore_y, output, 1 bit: registered match flag.
REQ-014 Port match_cnt, output, CNT_W bits: number of matches.

Function
REQ-015 The FSM SHALL have two states: UNCFG (entered on reset) and RUN.
REQ-016 cfg_ready SHALL be 1 in both states; a configuration is accepted on any cycle where cfg_valid is 1 (cfg_valid & cfg_ready).
REQ-017 On acceptance, the block SHALL latch pattern, length and overlap, clear the history and fill count, and clear match_cnt.
REQ-018 After acceptance, the FSM SHALL go to RUN if 2 <= cfg_len <= MAX_LEN, otherwise to UNCFG.
REQ-019 On a cycle where a configuration is accepted, in_valid SHALL be ignored (configuration wins).
REQ-020 In RUN, each cycle with in_valid=1 SHALL shift in_bit into the LSB of the history register and increment the fill count, saturating at MAX_LEN; cycles with in_valid=0 SHALL leave history and fill unchanged.
REQ-021 mealy_y SHALL be 1 iff all of the following hold: state is RUN; in_valid=1; no configuration is accepted this cycle; fill >= len-1; and the low len bits of {history, in_bit} equal the low len bits of the pattern.
REQ-022 moore_y SHALL equal mealy_y registered one cycle later, so it is high for exactly one cycle per match.
REQ-023 With overlap=1, a match SHALL leave the history and fill unaffected beyond the normal shift.
REQ-024 With overlap=0, a match SHALL set fill to 0, so the next match requires len fresh samples.
REQ-025 match_cnt SHALL increment by 1 on every cycle where mealy_y=1 and SHALL saturate at 2^CNT_W-1.
REQ-026 In UNCFG, mealy_y and moore_y SHALL be 0 and history, fill and match_cnt SHALL hold.

Reset
REQ-027 Reset SHALL immediately force: state=UNCFG, history=0, fill=0, moore_y=0, match_cnt=0, and stored pattern, length and overlap to 0.
REQ-028 A reset asserted mid-pattern SHALL discard all partial progress; mealy_y SHALL be 0 while reset is asserted.

Configuration
REQ-029 Macro SEQ_PATTERN_DET_CNT_EN defined: the match counter SHALL be present as specified.
REQ-030 Macro SEQ_PATTERN_DET_CNT_EN undefined: no counter registers SHALL exist, match_cnt SHALL be tied to 0, and all other behaviour SHALL be unchanged.

Structure
REQ-031 Package seq_pattern_det_pkg SHALL hold the state enum typedef (UNCFG, RUN) and the default MAX_LEN and CNT_W constants.
REQ-032 Sub-module seq_pattern_hist SHALL implement the history shift register and the saturating fill counter, with shift, clear and fill-output ports.

Verification
REQ-033 Configure 1101, len=4, overlap=1; feed 1,1,0,1,1,0,1 -> mealy_y high on samples 4 and 7, moore_y high on the following cycles, match_cnt=2.
REQ-034 Same input with overlap=0 -> mealy_y high on sample 4 only, match_cnt=1.
REQ-035 Configure 1110, len=4; feed 1,1,1,1,0 with in_valid low for 2 cycles between samples 2 and 3 -> single match on sample 5, no spurious output during the gap cycles.
REQ-036 Configure 1101 and feed 1,1,0; then assert reset for 1 cycle, reconfigure, and feed 1 -> no match and match_cnt=0; also check that cfg_len=0 or 9 (MAX_LEN=8) lands in UNCFG with outputs held at 0.
REQ-037 With CNT_W=2 and pattern 11, len=2, overlap=1, feed six 1s -> 5 matches and match_cnt saturates at 3; repeat without SEQ_PATTERN_DET_CNT_EN -> match_cnt=0.
REQ-038 Accept a new configuration on the same cycle as an otherwise-matching sample -> no match, history cleared.
